// File: rtl/rsa_wrapper_pkg.sv
// Shared types and constants for the RSA256 UART wrapper: controller states,
// load phases, byte counts and a byte shift-in helper.
package rsa_wrapper_pkg;

    typedef enum logic [2:0] {
        Q_RX,
        RD,
        CALC,
        Q_TX,
        WR
    } state_t;

    typedef enum logic [1:0] {
        KEY_N,
        KEY_D,
        DATA
    } phase_t;

    localparam int KEY_BYTES = 32;
    localparam int OUT_BYTES = 31;
    localparam int CNT_W     = 6;

    // First byte received ends up in the MSB after 32 shifts.
    function automatic logic [255:0] shift_in_byte(input logic [255:0] r, input logic [7:0] b);
        return {r[247:0], b};
    endfunction

endpackage

// File: rtl/avm_poll_ctrl.sv
// Single-transfer Avalon-MM master port: registers one read or write, holds it
// through waitrequest and flags the completing cycle with done.
module avm_poll_ctrl #(
    parameter logic [4:0] RESET_ADDR = 5'd2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        launch,
    input  logic        launch_write,
    input  logic [4:0]  launch_addr,
    input  logic [31:0] launch_wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);

    logic [4:0]  addr_reg;
    logic        read_reg;
    logic        write_reg;
    logic [31:0] wdata_reg;

    // A status poll is already outstanding when reset releases.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_reg  <= RESET_ADDR;
            read_reg  <= 1'b1;
            write_reg <= 1'b0;
            wdata_reg <= '0;
        end else if (launch) begin
            addr_reg  <= launch_addr;
            read_reg  <= ~launch_write;
            write_reg <= launch_write;
            wdata_reg <= launch_write ? launch_wdata : 32'd0;
        end else if (done) begin
            read_reg  <= 1'b0;
            write_reg <= 1'b0;
        end
    end

    assign done          = (read_reg | write_reg) & ~avm_waitrequest;
    assign rdata         = avm_readdata;
    assign avm_address   = addr_reg;
    assign avm_read      = read_reg;
    assign avm_write     = write_reg;
    assign avm_writedata = wdata_reg;

endmodule

// File: rtl/rsa256_uart_wrapper.sv
// Avalon master bridging the RS232 UART and Rsa256Core2: loads n, d, then
// decrypts 256-bit blocks forever. Optional RSA_WRAPPER_BLKCNT_EN adds o_blocks_done.
module rsa256_uart_wrapper
    import rsa_wrapper_pkg::*;
#(
    parameter logic [4:0] RX_ADDR     = 5'd0,
    parameter logic [4:0] TX_ADDR     = 5'd1,
    parameter logic [4:0] STATUS_ADDR = 5'd2,
    parameter int         RX_OK_BIT   = 7,
    parameter int         TX_OK_BIT   = 6
) (
    input  logic         i_clk,
    input  logic         i_rst,
    output logic [4:0]   avm_address,
    output logic         avm_read,
    input  logic [31:0]  avm_readdata,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic         avm_waitrequest,
    output logic         o_core_start,
    output logic [255:0] o_core_a,
    output logic [255:0] o_core_d,
    output logic [255:0] o_core_n,
    input  logic [255:0] i_core_a_pow_d,
`ifdef RSA_WRAPPER_BLKCNT_EN
    output logic [15:0]  o_blocks_done,
`endif
    input  logic         i_core_finished
);

    state_t       state_reg, state_next;
    phase_t       phase_reg, phase_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [255:0] n_reg, n_next;
    logic [255:0] d_reg, d_next;
    logic [255:0] a_reg, a_next;
    logic [247:0] tx_reg, tx_next;
    logic         start_reg, start_next;
`ifdef RSA_WRAPPER_BLKCNT_EN
    logic [15:0]  blocks_reg, blocks_next;
`endif

    logic         launch;
    logic         launch_write;
    logic [4:0]   launch_addr;
    logic [31:0]  launch_wdata;
    logic         done;
    logic [31:0]  rdata;

    avm_poll_ctrl #(
        .RESET_ADDR(STATUS_ADDR)
    ) u_avm (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .launch         (launch),
        .launch_write   (launch_write),
        .launch_addr    (launch_addr),
        .launch_wdata   (launch_wdata),
        .done           (done),
        .rdata          (rdata),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest)
    );

    // Result byte 31 is never sent, and only the flag/data bits of UART reads matter.
    logic unused_bits;
    assign unused_bits = ^{rdata[31:8], i_core_a_pow_d[255:248]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= Q_RX;
            phase_reg  <= KEY_N;
            cnt_reg    <= '0;
            n_reg      <= '0;
            d_reg      <= '0;
            a_reg      <= '0;
            tx_reg     <= '0;
            start_reg  <= 1'b0;
`ifdef RSA_WRAPPER_BLKCNT_EN
            blocks_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            cnt_reg    <= cnt_next;
            n_reg      <= n_next;
            d_reg      <= d_next;
            a_reg      <= a_next;
            tx_reg     <= tx_next;
            start_reg  <= start_next;
`ifdef RSA_WRAPPER_BLKCNT_EN
            blocks_reg <= blocks_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        phase_next   = phase_reg;
        cnt_next     = cnt_reg;
        n_next       = n_reg;
        d_next       = d_reg;
        a_next       = a_reg;
        tx_next      = tx_reg;
        start_next   = 1'b0;
`ifdef RSA_WRAPPER_BLKCNT_EN
        blocks_next  = blocks_reg;
`endif
        launch       = 1'b0;
        launch_write = 1'b0;
        launch_addr  = STATUS_ADDR;
        launch_wdata = 32'd0;

        unique case (state_reg)
            Q_RX: begin
                if (done) begin
                    launch = 1'b1;
                    if (rdata[RX_OK_BIT]) begin
                        launch_addr = RX_ADDR;
                        state_next  = RD;
                    end
                end
            end
            RD: begin
                if (done) begin
                    case (phase_reg)
                        KEY_N:   n_next = shift_in_byte(n_reg, rdata[7:0]);
                        KEY_D:   d_next = shift_in_byte(d_reg, rdata[7:0]);
                        default: a_next = shift_in_byte(a_reg, rdata[7:0]);
                    endcase
                    if (cnt_reg == CNT_W'(KEY_BYTES - 1)) begin
                        cnt_next = '0;
                        if (phase_reg == DATA) begin
                            // Bus goes idle for the whole computation.
                            state_next = CALC;
                            start_next = 1'b1;
                        end else begin
                            phase_next = (phase_reg == KEY_N) ? KEY_D : DATA;
                            state_next = Q_RX;
                            launch     = 1'b1;
                        end
                    end else begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = Q_RX;
                        launch     = 1'b1;
                    end
                end
            end
            CALC: begin
                if (i_core_finished) begin
                    tx_next    = i_core_a_pow_d[247:0];
                    state_next = Q_TX;
                    launch     = 1'b1;
                end
            end
            Q_TX: begin
                if (done) begin
                    launch = 1'b1;
                    if (rdata[TX_OK_BIT]) begin
                        launch_write = 1'b1;
                        launch_addr  = TX_ADDR;
                        launch_wdata = {24'd0, tx_reg[247:240]};
                        state_next   = WR;
                    end
                end
            end
            WR: begin
                if (done) begin
                    tx_next = {tx_reg[239:0], 8'd0};
                    launch  = 1'b1;
                    if (cnt_reg == CNT_W'(OUT_BYTES - 1)) begin
                        cnt_next   = '0;
                        state_next = Q_RX;
`ifdef RSA_WRAPPER_BLKCNT_EN
                        blocks_next = blocks_reg + 16'd1;
`endif
                    end else begin
                        cnt_next   = cnt_reg + CNT_W'(1);
                        state_next = Q_TX;
                    end
                end
            end
            default: state_next = Q_RX;
        endcase
    end

    assign o_core_start = start_reg;
    assign o_core_a     = a_reg;
    assign o_core_d     = d_reg;
    assign o_core_n     = n_reg;
`ifdef RSA_WRAPPER_BLKCNT_EN
    assign o_blocks_done = blocks_reg;
`endif

endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// Scoreboard bench: UART/Avalon slave model with stalls, core model, expected
// RX-driven start events and TX bytes checked as the wrapper produces them.
module tb_rsa256_uart_wrapper;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [4:0]   avm_address;
    logic         avm_read;
    logic [31:0]  avm_readdata;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic         avm_waitrequest;
    logic         o_core_start;
    logic [255:0] o_core_a;
    logic [255:0] o_core_d;
    logic [255:0] o_core_n;
    logic [255:0] i_core_a_pow_d;
    logic         i_core_finished;
`ifdef RSA_WRAPPER_BLKCNT_EN
    logic [15:0]  o_blocks_done;
`endif

    always #5 i_clk = ~i_clk;

    rsa256_uart_wrapper dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .o_core_start   (o_core_start),
        .o_core_a       (o_core_a),
        .o_core_d       (o_core_d),
        .o_core_n       (o_core_n),
        .i_core_a_pow_d (i_core_a_pow_d),
`ifdef RSA_WRAPPER_BLKCNT_EN
        .o_blocks_done  (o_blocks_done),
`endif
        .i_core_finished(i_core_finished)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0]   rx_q[$];
    logic [7:0]   tx_exp_q[$];
    logic [255:0] blk_q[$];
    logic [255:0] res_q[$];
    int           start_cyc_q[$];

    logic [255:0] key_n;
    logic [255:0] key_d;
    int  cyc = 0;
    int  stall_cycles = 0;
    int  stall_cnt = 0;
    int  hold_left = 0;
    int  rx_total = 0;
    int  tx_count = 0;
    int  core_cnt = 0;
    bit  core_busy = 0;
    bit  spur_pending = 0;
    bit  hold_valid = 0;
    logic [38:0] saved_bus;

    task automatic bus_complete();
        logic [31:0] r;
        logic [7:0]  b;
        r = $urandom;
        if (avm_read) begin
            if (avm_address == 5'd2) begin
                r[7] = (rx_q.size() > 0) && (hold_left == 0);
                r[6] = (hold_left == 0);
                if (hold_left > 0) hold_left--;
                avm_readdata = r;
            end else if (avm_address == 5'd0) begin
                if (rx_q.size() == 0) begin
                    chk("rx_underflow", 256'd1, 256'd0);
                    avm_readdata = r;
                end else begin
                    b = rx_q.pop_front();
                    avm_readdata = {r[31:8], b};
                    rx_total++;
                    if (rx_total > 64 && ((rx_total - 64) % 32) == 0)
                        start_cyc_q.push_back(cyc + 1);
                end
            end else begin
                chk("rd_addr", 256'(avm_address), 256'd2);
            end
        end else begin
            chk("wr_addr", 256'(avm_address), 256'd1);
            tx_count++;
            if (tx_exp_q.size() == 0) begin
                chk("tx_unexpected", 256'(avm_writedata), 256'd0);
            end else begin
                b = tx_exp_q.pop_front();
                chk("tx_byte", 256'(avm_writedata), 256'({24'd0, b}));
            end
        end
    endtask

    task automatic avalon_model();
        if (hold_valid)
            chk("stall_stable", 256'({avm_address, avm_read, avm_write, avm_writedata}), 256'(saved_bus));
        if (i_rst) begin
            avm_waitrequest = 1'b1;
            stall_cnt  = 0;
            hold_valid = 0;
            rx_total   = 0;
            start_cyc_q.delete();
        end else if (avm_read || avm_write) begin
            if (avm_read && avm_write) chk("rw_excl", 256'd1, 256'd0);
            if (stall_cnt < stall_cycles) begin
                stall_cnt++;
                avm_waitrequest = 1'b1;
                avm_readdata    = $urandom;
                hold_valid      = 1;
                saved_bus       = {avm_address, avm_read, avm_write, avm_writedata};
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt  = 0;
                hold_valid = 0;
                bus_complete();
            end
        end else begin
            avm_waitrequest = 1'b0;
            hold_valid = 0;
        end
    endtask

    task automatic core_model();
        logic [255:0] r;
        i_core_finished = 1'b0;
        if (i_rst) begin
            core_busy = 0;
        end else begin
            if (o_core_start) begin
                if (blk_q.size() == 0 || start_cyc_q.size() == 0) begin
                    chk("start_unexpected", 256'd1, 256'd0);
                end else begin
                    chk("start_cycle", 256'(cyc), 256'(start_cyc_q.pop_front()));
                    chk("core_a", o_core_a, blk_q.pop_front());
                    chk("core_n", o_core_n, key_n);
                    chk("core_d", o_core_d, key_d);
                end
                core_busy = 1;
                core_cnt  = 12;
            end else if (core_busy) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_busy = 0;
                    r = (res_q.size() > 0) ? res_q.pop_front() : 256'd0;
                    i_core_finished = 1'b1;
                    i_core_a_pow_d  = r;
                    for (int k = 0; k < 31; k++) tx_exp_q.push_back(r[247 - 8*k -: 8]);
                    hold_left = 5;
                end
            end else if (spur_pending) begin
                spur_pending    = 0;
                i_core_finished = 1'b1;
                i_core_a_pow_d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        cyc++;
        avalon_model();
        core_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_read"},  256'(avm_read), 256'd1);
        chk({tag, "_addr"},  256'(avm_address), 256'd2);
        chk({tag, "_write"}, 256'({avm_write, avm_writedata}), 256'd0);
        chk({tag, "_start"}, 256'(o_core_start), 256'd0);
        chk({tag, "_n"}, o_core_n, 256'd0);
        chk({tag, "_d"}, o_core_d, 256'd0);
        chk({tag, "_a"}, o_core_a, 256'd0);
    endtask

    task automatic push_word(input logic [255:0] w);
        for (int i = 31; i >= 0; i--) rx_q.push_back(w[i*8 +: 8]);
    endtask

    initial begin
        logic [255:0] blk;
        logic [255:0] res;
        i_rst = 1'b1;
        avm_waitrequest = 1'b1;
        avm_readdata = 32'd0;
        i_core_finished = 1'b0;
        i_core_a_pow_d = '0;
        key_n = 256'hCA3586E7_1F2E3D4C_5B6A7988_97A6B5C4_D3E2F101_12233445_5667788A_029CF831;
        key_d = 256'hB6ACE0B1_0A1B2C3D_4E5F6071_8293A4B5_C6D7E8F9_11223344_55667788_BCF46BD9;

        repeat (3) tick();
        check_reset_outputs("reset");
        i_rst = 1'b0;

        // Partial key followed by a mid-load reset.
        for (int i = 0; i < 10; i++) rx_q.push_back(8'($urandom));
        for (int i = 0; i < 500 && rx_total < 10; i++) tick();
        chk("partial_key_read", 256'(rx_total), 256'd10);
        repeat (3) tick();
        i_rst = 1'b1;
        repeat (2) tick();
        check_reset_outputs("midreset");
        i_rst = 1'b0;
        rx_q.delete();

        // Full key under stalls, RRDY holdoff and a stray finished pulse.
        stall_cycles = 3;
        hold_left    = 5;
        spur_pending = 1;
        push_word(key_n);
        push_word(key_d);
        for (int i = 0; i < 5000 && rx_total < 64; i++) tick();
        chk("key_bytes", 256'(rx_total), 256'd64);
        repeat (10) tick();
        chk("key_n", o_core_n, key_n);
        chk("key_d", o_core_d, key_d);
        chk("no_start_in_key", 256'(o_core_start), 256'd0);

        // Block 1 with the fixed 0x01..0x1F result.
        hold_left = 5;
        blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        res[255:248] = 8'hAB;
        for (int k = 0; k < 31; k++) res[247 - 8*k -: 8] = 8'(k + 1);
        blk_q.push_back(blk);
        res_q.push_back(res);
        push_word(blk);
        for (int i = 0; i < 6000 && tx_count < 31; i++) tick();
        chk("blk1_tx_count", 256'(tx_count), 256'd31);
        repeat (2) tick();
        chk("rx_poll_resumed", 256'({avm_read, avm_address}), 256'({1'b1, 5'd2}));

        // Block 2 without stalls; key must be reused.
        stall_cycles = 0;
        blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        res = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        blk_q.push_back(blk);
        res_q.push_back(res);
        push_word(blk);
        for (int i = 0; i < 6000 && tx_count < 62; i++) tick();
        chk("blk2_tx_count", 256'(tx_count), 256'd62);
        repeat (20) tick();
        chk("rx_total", 256'(rx_total), 256'd128);
        chk("rx_q_drained", 256'(rx_q.size()), 256'd0);
        chk("blk_q_drained", 256'(blk_q.size()), 256'd0);
        chk("tx_exp_drained", 256'(tx_exp_q.size()), 256'd0);
        chk("tx_total_stable", 256'(tx_count), 256'd62);
`ifdef RSA_WRAPPER_BLKCNT_EN
        chk("blocks_done", 256'(o_blocks_done), 256'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
